switch_debounce_led: RTL and testbench

//   Board-side receiver for the SW0/SW1 slide-switch inputs. Synchronises each raw switch to CLK,

---
 rtl/phys476_io_pkg.sv | 22 ++
 rtl/switch_debouncer.sv | 51 +++++
 rtl/switch_debounce_led.sv | 83 ++++++++
 tb/tb_switch_debounce_led.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/phys476_io_pkg.sv
// Shared switch/button I/O definitions: default timing constants and the edge-event record
// reused by every debounced-input consumer.
package phys476_io_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 1000;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_BLINK_DIV       = 25000000;

    // SW0 is lane 0, SW1 is lane 1.
    localparam int NUM_SW = 2;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_evt_t;

    // One spare bit so a count up to `cycles` never needs to wrap.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One switch lane: synchroniser chain, stability counter, registered level and one-cycle
// rise/fall pulses that coincide with the level change.
module switch_debouncer
    import phys476_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic [CW-1:0]          cnt;

    assign sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_ff <= '0;
            stable  <= 1'b0;
            cnt     <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
            rise    <= 1'b0;
            fall    <= 1'b0;
            // Any agreeing sample restarts the run, so short glitches never accumulate.
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync;
                cnt    <= '0;
                rise   <= sync;
                fall   <= ~sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_debounce_led.sv
// Slide-switch front end: two debounced lanes drive LED0/LED1, LED2 follows a toggle that
// SW0 rises flip and SW1 rises clear. Define LED_BLINK_EN to blink LED2 while the toggle is set.
module switch_debounce_led
    import phys476_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int BLINK_DIV       = DEF_BLINK_DIV
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW0,
    input  logic SW1,
    output logic LED0,
    output logic LED1,
    output logic LED2
);

    logic      [NUM_SW-1:0] sw_raw;
    logic      [NUM_SW-1:0] sw_stable;
    logic      [NUM_SW-1:0] fall_unused;
    edge_evt_t [NUM_SW-1:0] sw_evt;
    logic                   toggle;

    assign sw_raw = {SW1, SW0};

    generate
        for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
            logic r, f;
            switch_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES)
            ) u_deb (
                .CLK   (CLK),
                .RST   (RST),
                .raw   (sw_raw[i]),
                .stable(sw_stable[i]),
                .rise  (r),
                .fall  (f)
            );
            assign sw_evt[i]      = '{rise: r, fall: f};
            assign fall_unused[i] = sw_evt[i].fall;
        end
    endgenerate

    // Clear beats flip when both lanes accept a rise in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST)                 toggle <= 1'b0;
        else if (sw_evt[1].rise) toggle <= 1'b0;
        else if (sw_evt[0].rise) toggle <= ~toggle;
    end

    assign LED0 = sw_stable[0];
    assign LED1 = sw_stable[1];

`ifdef LED_BLINK_EN
    localparam int            DW       = cnt_width(BLINK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BLINK_DIV - 1);

    logic [DW-1:0] blink_cnt;
    logic          phase;

    // Held at zero while the toggle is clear, so every blink run starts with a dark half-period.
    always_ff @(posedge CLK) begin
        if (RST || !toggle) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == DIV_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign LED2 = toggle & phase;
`else
    logic [31:0] blink_div_unused;
    assign blink_div_unused = 32'(BLINK_DIV);
    assign LED2 = toggle;
`endif

endmodule

// File: tb/tb_switch_debounce_led.sv
// Directed vector table, hand-written reset/blink sequence, then random switch activity
// checked against a sample-window reference model.
module tb_switch_debounce_led;

    localparam int D  = 4;
    localparam int S  = 2;
    localparam int B  = 8;
    localparam int HL = S + D;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic SW0 = 1'b0;
    logic SW1 = 1'b0;
    logic LED0, LED1, LED2;

    int n_cmp = 0;
    int n_bad = 0;

    switch_debounce_led #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S),
        .BLINK_DIV      (B)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .SW0 (SW0),
        .SW1 (SW1),
        .LED0(LED0),
        .LED1(LED1),
        .LED2(LED2)
    );

    always #5 CLK = ~CLK;

    // Reference model: hist[s][0] is the most recent raw sample; the synchroniser output seen at
    // an edge is hist[s][S-1]. A level is accepted once D consecutive synced samples disagree.
    bit mh[2][HL];
    bit ms[2];
    bit mrp[2];
    bit mtog;
    int mn;

    task automatic model_step(input bit rst, input bit s0, input bit s1);
        bit sw[2];
        bit acc;
        bit ntog;
        sw[0] = s0;
        sw[1] = s1;
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < HL; i++) mh[s][i] = 1'b0;
                ms[s]  = 1'b0;
                mrp[s] = 1'b0;
            end
            mtog = 1'b0;
            mn   = 0;
        end else begin
            ntog = mrp[1] ? 1'b0 : (mrp[0] ? ~mtog : mtog);
            mn   = (mtog && ntog) ? mn + 1 : 0;
            mtog = ntog;
            for (int s = 0; s < 2; s++) begin
                acc = 1'b1;
                for (int i = 0; i < D; i++)
                    if (mh[s][S-1+i] == ms[s]) acc = 1'b0;
                mrp[s] = acc && !ms[s];
                if (acc) ms[s] = ~ms[s];
                for (int i = HL - 1; i > 0; i--) mh[s][i] = mh[s][i-1];
                mh[s][0] = sw[s];
            end
        end
    endtask

    function automatic bit model_led2();
`ifdef LED_BLINK_EN
        return mtog && (((mn / B) % 2) == 1);
`else
        return mtog;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_step(RST, SW0, SW1);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit rst;
        bit sw0;
        bit sw1;
        int hold;
        bit l0;
        bit l1;
        bit l2;
    } vec_t;

    vec_t vt[$];

    initial begin
        // reset with switches high, then simultaneous acceptance (clear wins)
        vt.push_back('{1, 1, 1, 3, 0, 0, 0});
        vt.push_back('{0, 1, 1, 5, 0, 0, 0});
        vt.push_back('{0, 1, 1, 1, 1, 1, 0});
        vt.push_back('{0, 1, 1, 1, 1, 1, 0});
        vt.push_back('{0, 0, 0, 8, 0, 0, 0});
        // SW0 rise: LED0 after 6, LED2 one later; fall leaves LED2
        vt.push_back('{0, 1, 0, 6, 1, 0, 0});
        vt.push_back('{0, 1, 0, 1, 1, 0, 1});
        vt.push_back('{0, 0, 0, 8, 0, 0, 1});
        // bounce rejected, then one clean rise flips LED2 once
        vt.push_back('{0, 1, 0, 2, 0, 0, 1});
        vt.push_back('{0, 0, 0, 2, 0, 0, 1});
        vt.push_back('{0, 1, 0, 2, 0, 0, 1});
        vt.push_back('{0, 0, 0, 2, 0, 0, 1});
        vt.push_back('{0, 1, 0, 7, 1, 0, 0});
        // 3-cycle SW1 pulse rejected
        vt.push_back('{0, 1, 1, 3, 1, 0, 0});
        vt.push_back('{0, 1, 0, 8, 1, 0, 0});
        // SW1 rise clears LED2 one cycle after LED1; SW1 fall keeps it clear
        vt.push_back('{0, 0, 0, 8, 0, 0, 0});
        vt.push_back('{0, 1, 0, 7, 1, 0, 1});
        vt.push_back('{0, 1, 1, 6, 1, 1, 1});
        vt.push_back('{0, 1, 1, 1, 1, 1, 0});
        vt.push_back('{0, 1, 0, 8, 1, 0, 0});
        // coincident rises with LED2 set, then SW0 fall
        vt.push_back('{0, 0, 0, 8, 0, 0, 0});
        vt.push_back('{0, 1, 0, 7, 1, 0, 1});
        vt.push_back('{0, 0, 0, 8, 0, 0, 1});
        vt.push_back('{0, 1, 1, 7, 1, 1, 0});
        vt.push_back('{0, 0, 1, 8, 0, 1, 0});
        vt.push_back('{0, 0, 0, 8, 0, 0, 0});

        for (int v = 0; v < vt.size(); v++) begin
            RST = vt[v].rst;
            SW0 = vt[v].sw0;
            SW1 = vt[v].sw1;
            for (int h = 0; h < vt[v].hold; h++) tick();
            chk($sformatf("vec%0d_led0", v), LED0, vt[v].l0);
            chk($sformatf("vec%0d_led1", v), LED1, vt[v].l1);
`ifdef LED_BLINK_EN
            if (!vt[v].l2) chk($sformatf("vec%0d_led2", v), LED2, 0);
`else
            chk($sformatf("vec%0d_led2", v), LED2, vt[v].l2);
`endif
        end

        // reset mid-count discards the pending acceptance
        SW0 = 1'b1;
        repeat (4) tick();
        RST = 1'b1;
        tick();
        chk("midrst_led0", LED0, 0);
        chk("midrst_led1", LED1, 0);
        chk("midrst_led2", LED2, 0);
        RST = 1'b0;
        repeat (5) tick();
        chk("restart_led0_early", LED0, 0);
        tick();
        chk("restart_led0", LED0, 1);
        chk("restart_led2_pre", LED2, 0);
        for (int k = 0; k < 3 * B; k++) begin
            tick();
`ifdef LED_BLINK_EN
            chk($sformatf("blink%0d", k), LED2, ((k / B) == 1) ? 1 : 0);
`else
            chk($sformatf("steady%0d", k), LED2, 1);
`endif
        end

        // random activity against the model
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        for (int r = 0; r < 600; r++) begin
            int hold;
            hold = $urandom_range(1, 8);
            SW0  = 1'($urandom_range(0, 1));
            SW1  = 1'($urandom_range(0, 1));
            RST  = ($urandom_range(0, 59) == 0);
            for (int h = 0; h < hold; h++) begin
                tick();
                RST = 1'b0;
                chk("rand_led0", LED0, ms[0]);
                chk("rand_led1", LED1, ms[1]);
                chk("rand_led2", LED2, model_led2());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
